tilt_shape_sequencer: RTL and testbench
=======================================

Name: tilt_shape_sequencer

Overview:
- Periodic frame sequencer between the accelerometer front end and the line-drawing engine.
- On each update tick it samples two signed tilt axes, filters and clamps them, requests a frame-buffer clear, then issues 1 or 2 line segments over a valid/ready handshake.
- Generalises the single fixed tilted line to two axes, a parametrised screen, tick rate and length, and a selectable line/cross mode, with smoothing, clamping and overrun reporting.

Parameters:
- P_COORD_W, 16, width of the signed tilt inputs and of the unsigned coordinate outputs.
- P_SCREEN_W, 640, screen width in pixels.
- P_SCREEN_H, 480, screen height in pixels.
- P_CX, 320, centre x.
- P_CY, 240, centre y.
- P_HALF_LEN, 75, half length of each segment along its major axis.
- P_TICK_DIV, 1666666, clock cycles per update tick (>=8).
- P_SHIFT, 4, right arithmetic shift applied to raw tilt.
- P_MAX_OFF, 200, magnitude clamp for the tilt offset and the pan.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_enable  in  1  allow new frames to start.
- i_mode  in  1  0 = single line, 1 = cross (two segments).
- i_tilt_x  in  P_COORD_W  signed tilt that sets line slope.
- i_tilt_y  in  P_COORD_W  signed tilt that sets vertical pan.
- o_clear_req  out  1  frame-buffer clear request (level).
- i_clear_done  in  1  drawer has finished the clear (1-cycle pulse or level).
- o_seg_valid  out  1  segment coordinates valid.
- i_seg_ready  in  1  drawer accepts the segment.
- o_x0, o_y0, o_x1, o_y1  out  P_COORD_W each  segment endpoints, unsigned pixels.
- o_busy  out  1  high in any state other than IDLE.
- o_frame_count  out  16  frames completed, wraps.
- o_overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (async, i_reset_n=0): all outputs 0, state IDLE, tick counter 0, filter state s=0, overrun 0. Reset mid-frame aborts immediately with no partial segment held.
- Tick counter: counts 0..P_TICK_DIV-1 and wraps. Tick is a 1-cycle pulse at count P_TICK_DIV-1. The counter runs regardless of state.
- IDLE: on tick with i_enable=1, go to SAMPLE.
- SAMPLE (1 cycle):
  - t = i_tilt_x>>>P_SHIFT.
  - s <= clamp(s + ((t - s)>>>2), ±P_MAX_OFF).
  - p = clamp(i_tilt_y>>>P_SHIFT, ±P_MAX_OFF), unfiltered.
  - Latch i_mode.
  - Arithmetic uses P_COORD_W+2 signed bits internally.
  - Go to CLEAR.
- CLEAR: o_clear_req=1 from the first CLEAR cycle until i_clear_done is sampled high. i_clear_done in the same cycle as entry counts. o_clear_req drops in the next cycle, then go to EMIT with idx=0.
- EMIT: o_seg_valid=1 with coordinates registered and stable until handshake (valid & ready on a rising edge). Valid is never withdrawn before handshake.
  - Segment 0: (P_CX-P_HALF_LEN, P_CY+s+p) to (P_CX+P_HALF_LEN, P_CY-s+p).
  - Segment 1 (mode 1 only): (P_CX-s, P_CY-P_HALF_LEN+p) to (P_CX+s, P_CY+P_HALF_LEN+p).
  - Each coordinate is clamped to [0, P_SCREEN_W-1] for x and [0, P_SCREEN_H-1] for y.
  - On handshake of the last segment: o_seg_valid=0 next cycle, o_frame_count++, go to IDLE. Otherwise idx++ and present the next segment in the next cycle with valid held high.
- Tick while o_busy=1: ignored and o_overrun set to 1. o_overrun is cleared only by reset.
- i_enable low mid-frame: the current frame completes, and no new frame starts.
- Changes to i_mode or the tilt inputs after SAMPLE have no effect until the next frame.
- Worst-case frame length = 1 + clear latency + segment handshakes. No combinational path from any input to any output.

Test Plan:
- Bench uses P_TICK_DIV=100 unless stated. Reset, i_enable=1, i_mode=0, tilt_x=320, tilt_y=0, ready/clear_done tied high -> first frame s=5, one segment (245,245)-(395,235), frame_count=1; second frame s=8 -> (245,248)-(395,232).
- Mode 1, tilt_x=0, tilt_y=160, after filter settles (s=0) -> segments (245,250)-(395,250) then (320,175)-(320,325), frame_count +1 per tick.
- tilt_x=-32768, tilt_y=32767 -> s clamps to -200 and p to 200. Segment 0 = (245,240)-(395,479): y1=640 is clamped to 479.
- i_seg_ready held low for 50 cycles -> o_seg_valid stays 1 with stable coordinates, ticks in that window set o_overrun=1, and no frame is skipped mid-stream.
- i_clear_done delayed 30 cycles -> o_clear_req is high for exactly those cycles and o_seg_valid stays 0 until clear completes.
- Assert i_reset_n low in mid-EMIT -> o_seg_valid, o_clear_req, o_busy and coordinates go to 0 asynchronously; after release, s restarts from 0.

Source files
------------

// File: rtl/tilt_shape_sequencer.sv
// tilt_shape_sequencer: per-tick tilt sampling, frame clear request and line/cross segment emission
module tilt_shape_sequencer #(
  parameter int P_COORD_W  = 16,
  parameter int P_SCREEN_W = 640,
  parameter int P_SCREEN_H = 480,
  parameter int P_CX       = 320,
  parameter int P_CY       = 240,
  parameter int P_HALF_LEN = 75,
  parameter int P_TICK_DIV = 1666666,
  parameter int P_SHIFT    = 4,
  parameter int P_MAX_OFF  = 200
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_mode,
  input  logic [P_COORD_W-1:0] i_tilt_x,
  input  logic [P_COORD_W-1:0] i_tilt_y,
  output logic                 o_clear_req,
  input  logic                 i_clear_done,
  output logic                 o_seg_valid,
  input  logic                 i_seg_ready,
  output logic [P_COORD_W-1:0] o_x0,
  output logic [P_COORD_W-1:0] o_y0,
  output logic [P_COORD_W-1:0] o_x1,
  output logic [P_COORD_W-1:0] o_y1,
  output logic                 o_busy,
  output logic [15:0]          o_frame_count,
  output logic                 o_overrun
);
  localparam int W2 = P_COORD_W + 2;
  localparam int CW = $clog2(P_TICK_DIV);
  localparam logic signed [W2-1:0] MAXO = W2'(P_MAX_OFF);
  localparam logic signed [W2-1:0] CX   = W2'(P_CX);
  localparam logic signed [W2-1:0] CY   = W2'(P_CY);
  localparam logic signed [W2-1:0] HL   = W2'(P_HALF_LEN);
  localparam logic signed [W2-1:0] XMAX = W2'(P_SCREEN_W - 1);
  localparam logic signed [W2-1:0] YMAX = W2'(P_SCREEN_H - 1);
  typedef enum logic [1:0] {IDLE, SAMPLE, CLEAR, EMIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic tick, hs, last, mode_q, idx;
  logic signed [W2-1:0] s, p, tx, ty, t, d, s_n, p_n;
  logic [P_COORD_W-1:0] a_x0, a_y0, a_x1, a_y1, b_x0, b_y0, b_x1, b_y1;
  function automatic logic signed [W2-1:0] clamp_s(input logic signed [W2-1:0] v);
    return v > MAXO ? MAXO : v < -MAXO ? -MAXO : v;
  endfunction
  function automatic logic [P_COORD_W-1:0] clamp_u(input logic signed [W2-1:0] v, input logic signed [W2-1:0] hi);
    return v < 0 ? '0 : v > hi ? hi[P_COORD_W-1:0] : v[P_COORD_W-1:0];
  endfunction
  assign o_busy      = state != IDLE;
  assign o_clear_req = state == CLEAR;
  assign o_seg_valid = state == EMIT;
  always_comb begin
    tick = cnt == CW'(P_TICK_DIV - 1);
    hs   = state == EMIT && i_seg_ready;
    last = !mode_q || idx;
    tx   = {{2{i_tilt_x[P_COORD_W-1]}}, i_tilt_x};
    ty   = {{2{i_tilt_y[P_COORD_W-1]}}, i_tilt_y};
    t    = tx >>> P_SHIFT;
    d    = t - s;
    s_n  = clamp_s(s + (d >>> 2));
    p_n  = clamp_s(ty >>> P_SHIFT);
    a_x0 = clamp_u(CX - HL, XMAX);
    a_y0 = clamp_u(CY + s + p, YMAX);
    a_x1 = clamp_u(CX + HL, XMAX);
    a_y1 = clamp_u(CY - s + p, YMAX);
    b_x0 = clamp_u(CX - s, XMAX);
    b_y0 = clamp_u(CY - HL + p, YMAX);
    b_x1 = clamp_u(CX + s, XMAX);
    b_y1 = clamp_u(CY + HL + p, YMAX);
    state_n = state;
    case (state)
      IDLE:    state_n = tick && i_enable ? SAMPLE : IDLE;
      SAMPLE:  state_n = CLEAR;
      CLEAR:   state_n = i_clear_done ? EMIT : CLEAR;
      default: state_n = hs && last ? IDLE : EMIT;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      s             <= '0;
      p             <= '0;
      mode_q        <= 1'b0;
      idx           <= 1'b0;
      o_x0          <= '0;
      o_y0          <= '0;
      o_x1          <= '0;
      o_y1          <= '0;
      o_frame_count <= '0;
      o_overrun     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= tick ? '0 : cnt + 1'b1;
      if (tick && state != IDLE) o_overrun <= 1'b1;
      if (state == SAMPLE) begin
        s      <= s_n;
        p      <= p_n;
        mode_q <= i_mode;
      end
      if (state == CLEAR && i_clear_done) begin
        idx  <= 1'b0;
        o_x0 <= a_x0;
        o_y0 <= a_y0;
        o_x1 <= a_x1;
        o_y1 <= a_y1;
      end
      if (hs && last) o_frame_count <= o_frame_count + 16'd1;
      if (hs && !last) begin
        idx  <= 1'b1;
        o_x0 <= b_x0;
        o_y0 <= b_y0;
        o_x1 <= b_x1;
        o_y1 <= b_y1;
      end
    end
  end
endmodule

// File: tb/tb_tilt_shape_sequencer.sv
// tb_tilt_shape_sequencer: frame vectors plus stall, slow-clear, enable and reset sequences
module tb_tilt_shape_sequencer;
  logic clk, rst_n, en, mode, clear_done, ready;
  logic [15:0] tilt_x, tilt_y;
  logic clear_req, valid, busy, overrun;
  logic [15:0] x0, y0, x1, y1, fc;
  int total, passed;

  tilt_shape_sequencer #(.P_TICK_DIV(100)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
    .i_tilt_x(tilt_x), .i_tilt_y(tilt_y), .o_clear_req(clear_req),
    .i_clear_done(clear_done), .o_seg_valid(valid), .i_seg_ready(ready),
    .o_x0(x0), .o_y0(y0), .o_x1(x1), .o_y1(y1), .o_busy(busy),
    .o_frame_count(fc), .o_overrun(overrun)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    int tx, ty, m;
    int ax0, ay0, ax1, ay1, bx0, by0, bx1, by1;
  } vec_t;
  vec_t vecs[13];

  function automatic vec_t mk(input int tx, ty, m, ax0, ay0, ax1, ay1, bx0, by0, bx1, by1);
    vec_t v;
    v.tx = tx; v.ty = ty; v.m = m;
    v.ax0 = ax0; v.ay0 = ay0; v.ax1 = ax1; v.ay1 = ay1;
    v.bx0 = bx0; v.by0 = by0; v.bx1 = bx1; v.by1 = by1;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait_timeout", int'(n < 400), 1);
  endtask

  task automatic check_seg(input string tag, input int ex0, ey0, ex1, ey1);
    check({tag, "_x0"}, int'(x0), ex0);
    check({tag, "_y0"}, int'(y0), ey0);
    check({tag, "_x1"}, int'(x1), ex1);
    check({tag, "_y1"}, int'(y1), ey1);
  endtask

  initial begin
    logic [15:0] hx0, hy0, hx1, hy1;
    int ok, n, fc0;
    total = 0; passed = 0;
    vecs[0]  = mk(320, 0, 0,      245, 245, 395, 235,  0, 0, 0, 0);
    vecs[1]  = mk(320, 0, 0,      245, 248, 395, 232,  0, 0, 0, 0);
    vecs[2]  = mk(0, 160, 1,      245, 256, 395, 244,  314, 175, 326, 325);
    vecs[3]  = mk(0, 160, 1,      245, 254, 395, 246,  316, 175, 324, 325);
    vecs[4]  = mk(0, 160, 1,      245, 253, 395, 247,  317, 175, 323, 325);
    vecs[5]  = mk(0, 160, 1,      245, 252, 395, 248,  318, 175, 322, 325);
    vecs[6]  = mk(0, 160, 1,      245, 251, 395, 249,  319, 175, 321, 325);
    vecs[7]  = mk(0, 160, 1,      245, 250, 395, 250,  320, 175, 320, 325);
    vecs[8]  = mk(0, 160, 1,      245, 250, 395, 250,  320, 175, 320, 325);
    vecs[9]  = mk(-32768, 32767, 0, 245, 240, 395, 479, 0, 0, 0, 0);
    vecs[10] = mk(-32768, 32767, 0, 245, 240, 395, 479, 0, 0, 0, 0);
    vecs[11] = mk(-32768, 32767, 1, 245, 240, 395, 479, 520, 365, 120, 479);
    vecs[12] = mk(32767, -32768, 1, 245, 240, 395, 0,   120, 0, 520, 115);

    rst_n = 0; en = 1; mode = 0; clear_done = 1; ready = 1;
    tilt_x = 16'd320; tilt_y = 16'd0;
    #23;
    check("rst_valid", int'(valid), 0);
    check("rst_clear_req", int'(clear_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fc", int'(fc), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_x0", int'(x0), 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      tilt_x = 16'(vecs[i].tx);
      tilt_y = 16'(vecs[i].ty);
      mode = vecs[i].m[0];
      wait_valid();
      check_seg($sformatf("v%0d_s0", i), vecs[i].ax0, vecs[i].ay0, vecs[i].ax1, vecs[i].ay1);
      if (vecs[i].m != 0) begin
        @(negedge clk);
        check($sformatf("v%0d_s1_valid", i), int'(valid), 1);
        check_seg($sformatf("v%0d_s1", i), vecs[i].bx0, vecs[i].by0, vecs[i].bx1, vecs[i].by1);
      end
      @(negedge clk);
      check($sformatf("v%0d_done_valid", i), int'(valid), 0);
      check($sformatf("v%0d_fc", i), int'(fc), i + 1);
    end
    check("no_overrun_yet", int'(overrun), 0);

    // stall: ready low across a tick; late input changes must not affect this frame
    @(negedge clk);
    tilt_x = 16'd32767; tilt_y = 16'h8000; mode = 0; ready = 0;
    wait_valid();
    check_seg("stall", 245, 240, 395, 0);
    hx0 = x0; hy0 = y0; hx1 = x1; hy1 = y1;
    mode = 1; tilt_x = 16'd0; tilt_y = 16'd0;
    ok = 1;
    repeat (120) begin
      @(negedge clk);
      if (!valid || x0 != hx0 || y0 != hy0 || x1 != hx1 || y1 != hy1) ok = 0;
    end
    check("stall_stable", ok, 1);
    check("stall_overrun", int'(overrun), 1);
    check("stall_fc_held", int'(fc), 13);
    ready = 1;
    @(negedge clk);
    check("stall_single_seg", int'(valid), 0);
    check("stall_fc", int'(fc), 14);
    tilt_x = 16'd32767; tilt_y = 16'h8000; mode = 0;

    // slow clear: clear_done held off 30 cycles after the request appears
    clear_done = 0;
    n = 0;
    while (!clear_req && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("clear_wait_timeout", int'(n < 400), 1);
    ok = 1;
    repeat (30) begin
      if (!clear_req || valid) ok = 0;
      @(negedge clk);
    end
    check("clear_held", ok, 1);
    clear_done = 1;
    @(negedge clk);
    check("clear_dropped", int'(clear_req), 0);
    check("clear_valid", int'(valid), 1);
    check_seg("clear_seg", 245, 240, 395, 0);
    @(negedge clk);
    check("clear_fc", int'(fc), 15);

    // enable low: no new frame
    en = 0;
    fc0 = int'(fc);
    ok = 1;
    repeat (250) begin
      @(negedge clk);
      if (busy) ok = 0;
    end
    check("disabled_idle", ok, 1);
    check("disabled_fc", int'(fc), fc0);

    // async reset in the middle of EMIT
    en = 1; ready = 0;
    wait_valid();
    rst_n = 0;
    #1;
    check("ar_valid", int'(valid), 0);
    check("ar_clear_req", int'(clear_req), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_x0", int'(x0), 0);
    check("ar_y0", int'(y0), 0);
    check("ar_x1", int'(x1), 0);
    check("ar_y1", int'(y1), 0);
    check("ar_fc", int'(fc), 0);
    check("ar_overrun", int'(overrun), 0);
    @(negedge clk);
    tilt_x = 16'd320; tilt_y = 16'd0; mode = 0; ready = 1;
    rst_n = 1;
    wait_valid();
    check_seg("post_rst", 245, 245, 395, 235);
    @(negedge clk);
    check("post_rst_fc", int'(fc), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
